// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-Lite slave front end that turns single AHB transfers into APB SETUP/ACCESS sequences.
// Optional macro PSLVERR_EN: an APB slave error completes the AHB transfer with an ERROR response.
module ahb_apb_bridge_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          NSLV      = 4,
    parameter int          SLV_SHIFT = 12,
    parameter int          TIMEOUT   = 16
) (
    input  logic            hclk,
    input  logic            hresetn,
    input  logic [31:0]     haddr,
    input  logic            hwrite,
    input  logic [1:0]      htrans,
    input  logic            hready_in,
    input  logic [31:0]     hwdata,
    output logic            hreadyout,
    output logic            hresp,
    output logic [31:0]     hrdata,
    output logic [31:0]     paddr,
    output logic [31:0]     pwdata,
    output logic            pwrite,
    output logic [NSLV-1:0] psel,
    output logic            penable,
    input  logic [31:0]     prdata,
    input  logic            pready,
    input  logic            pslverr
);

    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] TMO_LAST = TW'(TLAST);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
    } state_t;

    state_t          state;
    logic [NSLV-1:0] sel_q;
    logic [NSLV-1:0] sel_dec;
    logic [31:0]     off;
    logic [31:0]     slot;
    logic            addr_ok;
    logic            accept;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;
    logic            slv_err;

`ifdef PSLVERR_EN
    assign slv_err = pslverr;
`else
    logic unused_pslverr;
    assign unused_pslverr = pslverr;
    assign slv_err        = 1'b0;
`endif

    always_comb begin
        off     = haddr - BASE_ADDR;
        slot    = off >> SLV_SHIFT;
        addr_ok = (haddr >= BASE_ADDR) && (slot < 32'(NSLV));
        accept  = hready_in && htrans[1];
        sel_dec = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel_dec[i] = addr_ok && (slot == 32'(i));
        end
        tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST) && !pready;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            psel      <= '0;
            penable   <= 1'b0;
            sel_q     <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    hresp <= 1'b0;
                    if (accept) begin
                        hreadyout <= 1'b0;
                        if (addr_ok) begin
                            paddr  <= haddr;
                            pwrite <= hwrite;
                            sel_q  <= sel_dec;
                            state  <= S_LATCH;
                        end else begin
                            hresp <= 1'b1;
                            state <= S_ERR1;
                        end
                    end
                end
                // hwdata is valid in the first data-phase cycle, which is LATCH
                S_LATCH: begin
                    if (pwrite) pwdata <= hwdata;
                    psel  <= sel_q;
                    state <= S_SETUP;
                end
                S_SETUP: begin
                    penable <= 1'b1;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        psel    <= '0;
                        penable <= 1'b0;
                        tmo_cnt <= '0;
                        if (slv_err) begin
                            hresp <= 1'b1;
                            state <= S_ERR1;
                        end else begin
                            if (!pwrite) hrdata <= prdata;
                            hreadyout <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else if (tmo_hit) begin
                        psel    <= '0;
                        penable <= 1'b0;
                        tmo_cnt <= '0;
                        hresp   <= 1'b1;
                        state   <= S_ERR1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                // Two-cycle ERROR: first with hreadyout low, then high
                S_ERR1: begin
                    hreadyout <= 1'b1;
                    state     <= S_ERR2;
                end
                S_ERR2: begin
                    hresp <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    psel      <= '0;
                    penable   <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Directed bench for ahb_apb_bridge_ctrl: single transfers, decode errors, timeout, reset and filtering.
module tb_ahb_apb_bridge_ctrl;

    logic        hclk;
    logic        hresetn;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic        hready_in;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic [3:0]  psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    ahb_apb_bridge_ctrl dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hready_in (hready_in),
        .hwdata    (hwdata),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Issue one transfer and follow it to the cycle where hreadyout returns high.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [1:0] trans,
                        input logic [31:0] wd, input int waits,
                        output int lowcnt, output int pencnt, output logic [3:0] psel_c2,
                        output logic pen_c3, output logic [3:0] psel_or, output logic rsp_end);
        int  acc;
        bit  done;
        haddr  = addr;
        hwrite = wr;
        htrans = trans;
        pready = 1'b0;
        tick();
        htrans  = 2'd0;
        hwdata  = wd;
        lowcnt  = 0;
        pencnt  = 0;
        acc     = 0;
        psel_c2 = '0;
        pen_c3  = 1'b0;
        psel_or = '0;
        rsp_end = 1'b0;
        done    = 1'b0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            if (cyc == 2) psel_c2 = psel;
            if (cyc == 3) pen_c3 = penable;
            psel_or = psel_or | psel;
            if (hreadyout) begin
                rsp_end = hresp;
                done    = 1'b1;
            end else begin
                lowcnt++;
                if (penable) begin
                    pencnt++;
                    pready = (acc >= waits);
                    acc++;
                end
                tick();
            end
        end
        chk("xfer_done", 32'(done), 32'd1);
        if (rsp_end) begin
            tick();
            chk("err_release", {30'd0, hreadyout, hresp}, 32'd2);
        end
    endtask

    int         lowcnt, pencnt;
    logic [3:0] psel_c2, psel_or;
    logic       pen_c3, rsp_end;
    logic       idle_ok;

    initial begin
        hresetn   = 1'b0;
        haddr     = '0;
        hwrite    = 1'b0;
        htrans    = 2'd0;
        hready_in = 1'b1;
        hwdata    = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_psel_pen", {27'd0, psel, penable}, 32'd0);
        hresetn = 1'b1;
        tick();

        // Single zero-wait write
        xfer(32'h8000_0000, 1'b1, 2'd2, 32'h24, 0, lowcnt, pencnt, psel_c2, pen_c3, psel_or, rsp_end);
        chk("wr_psel_c2", 32'(psel_c2), 32'h1);
        chk("wr_pen_c3", 32'(pen_c3), 32'd1);
        chk("wr_lowcnt", 32'(lowcnt), 32'd3);
        chk("wr_hresp", 32'(rsp_end), 32'd0);
        chk("wr_pwdata", pwdata, 32'h24);
        chk("wr_paddr", paddr, 32'h8000_0000);
        chk("wr_pwrite", 32'(pwrite), 32'd1);
        chk("wr_idle_psel", {27'd0, psel, penable}, 32'd0);

        // Read with two wait states, issued back-to-back in the completion cycle
        prdata = 32'hCAFE_F00D;
        xfer(32'h8000_2004, 1'b0, 2'd2, 32'h0, 2, lowcnt, pencnt, psel_c2, pen_c3, psel_or, rsp_end);
        chk("rd_psel_c2", 32'(psel_c2), 32'h4);
        chk("rd_lowcnt", 32'(lowcnt), 32'd5);
        chk("rd_pencnt", 32'(pencnt), 32'd3);
        chk("rd_hresp", 32'(rsp_end), 32'd0);
        chk("rd_hrdata", hrdata, 32'hCAFE_F00D);
        chk("rd_pwrite", 32'(pwrite), 32'd0);

        // Decode errors: just above the last slave and just below the window
        xfer(32'h8000_4000, 1'b0, 2'd2, 32'h0, 0, lowcnt, pencnt, psel_c2, pen_c3, psel_or, rsp_end);
        chk("oow_hi_psel", 32'(psel_or), 32'd0);
        chk("oow_hi_lowcnt", 32'(lowcnt), 32'd1);
        chk("oow_hi_hresp", 32'(rsp_end), 32'd1);
        xfer(32'h7FFF_FFFC, 1'b1, 2'd2, 32'h5, 0, lowcnt, pencnt, psel_c2, pen_c3, psel_or, rsp_end);
        chk("oow_lo_psel", 32'(psel_or), 32'd0);
        chk("oow_lo_lowcnt", 32'(lowcnt), 32'd1);
        chk("oow_lo_hresp", 32'(rsp_end), 32'd1);
        chk("oow_paddr_hold", paddr, 32'h8000_2004);

        // Hung slave: pready never rises
        prdata = 32'hDEAD_BEEF;
        xfer(32'h8000_1000, 1'b0, 2'd2, 32'h0, 1000, lowcnt, pencnt, psel_c2, pen_c3, psel_or, rsp_end);
        chk("tmo_pencnt", 32'(pencnt), 32'd16);
        chk("tmo_lowcnt", 32'(lowcnt), 32'd19);
        chk("tmo_psel", 32'(psel_or), 32'h2);
        chk("tmo_hresp", 32'(rsp_end), 32'd1);
        chk("tmo_hrdata", hrdata, 32'hCAFE_F00D);

        // Recovery after timeout, using a SEQ transfer to the last slave
        xfer(32'h8000_3000, 1'b1, 2'd3, 32'hA5A5_5A5A, 0, lowcnt, pencnt, psel_c2, pen_c3, psel_or, rsp_end);
        chk("rec_psel_c2", 32'(psel_c2), 32'h8);
        chk("rec_lowcnt", 32'(lowcnt), 32'd3);
        chk("rec_hresp", 32'(rsp_end), 32'd0);
        chk("rec_pwdata", pwdata, 32'hA5A5_5A5A);

        // APB slave error on a read
        prdata  = 32'h1234_5678;
        pslverr = 1'b1;
        xfer(32'h8000_3008, 1'b0, 2'd2, 32'h0, 0, lowcnt, pencnt, psel_c2, pen_c3, psel_or, rsp_end);
        pslverr = 1'b0;
`ifdef PSLVERR_EN
        chk("slverr_hresp", 32'(rsp_end), 32'd1);
        chk("slverr_lowcnt", 32'(lowcnt), 32'd4);
        chk("slverr_hrdata", hrdata, 32'hCAFE_F00D);
`else
        chk("slverr_hresp", 32'(rsp_end), 32'd0);
        chk("slverr_lowcnt", 32'(lowcnt), 32'd3);
        chk("slverr_hrdata", hrdata, 32'h1234_5678);
`endif

        // Transfers that must be ignored: IDLE, BUSY, and NONSEQ/SEQ without hready_in
        haddr = 32'h8000_0000;
        for (int p = 0; p < 4; p++) begin
            htrans    = 2'(p);
            hready_in = (p < 2);
            idle_ok   = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (psel != 4'd0 || !hreadyout) idle_ok = 1'b0;
            end
            htrans    = 2'd0;
            hready_in = 1'b1;
            chk("filter_no_xfer", 32'(idle_ok), 32'd1);
        end
        tick();

        // Reset asserted during ACCESS
        pready = 1'b0;
        haddr  = 32'h8000_0004;
        hwrite = 1'b0;
        htrans = 2'd2;
        tick();
        htrans = 2'd0;
        tick();
        tick();
        chk("rst_pre_pen", 32'(penable), 32'd1);
        #2;
        hresetn = 1'b0;
        #1;
        chk("rst_mid_psel_pen", {27'd0, psel, penable}, 32'd0);
        chk("rst_mid_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_mid_hrdata", hrdata, 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        tick();
        tick();
        chk("rst_after_idle", {26'd0, psel, penable, hreadyout}, 32'd1);

        // Normal read after reset
        prdata = 32'h77;
        xfer(32'h8000_0000, 1'b0, 2'd2, 32'h0, 1, lowcnt, pencnt, psel_c2, pen_c3, psel_or, rsp_end);
        chk("post_rst_hresp", 32'(rsp_end), 32'd0);
        chk("post_rst_hrdata", hrdata, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge_ctrl.md
Name: ahb_apb_bridge_ctrl

Overview:
- AHB-Lite slave front end and sequencer for the AHB-to-APB bridge; the target of the project's AHB master driver.
- Accepts single AHB transfers from the master and converts each into one APB SETUP/ACCESS sequence.
- Decodes the target APB slave and stretches the AHB data phase with `hreadyout` until the APB slave completes.
- Returns read data and OKAY/ERROR responses; guards against hung slaves with a wait-state timeout.

Parameters:
- BASE_ADDR, 32'h8000_0000, start of the APB window.
- NSLV, 4, number of APB slaves (psel width), 1..16.
- SLV_SHIFT, 12, log2 of bytes per slave region (4 KB regions).
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready before abort; 0 = no timeout.

Ports:
- hclk  in  1  bus clock, all logic on rising edge.
- hresetn  in  1  asynchronous active-low reset.
- haddr  in  32  AHB address (address phase).
- hwrite  in  1  1=write, 0=read (address phase).
- htrans  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- hready_in  in  1  AHB bus ready; a transfer is accepted only when high.
- hwdata  in  32  write data (data phase).
- hreadyout  out  1  0 = data phase stretched.
- hresp  out  1  0=OKAY, 1=ERROR.
- hrdata  out  32  read data, valid when hreadyout=1 at completion of a read.
- paddr  out  32  APB address.
- pwdata  out  32  APB write data.
- pwrite  out  1  APB direction.
- psel  out  NSLV  one-hot APB select.
- penable  out  1  APB ACCESS phase.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error; used only with PSLVERR_EN.

Behaviour:
- Reset (async, hresetn=0):
  - State goes to IDLE immediately.
  - Output reset values: hreadyout=1, hresp=0, hrdata=0, paddr=0, pwdata=0, pwrite=0, psel=0, penable=0, timeout counter=0.
  - Reset mid-transfer aborts the APB access with no completion; psel/penable drop asynchronously.
- All outputs are registered.
- Accept condition: in IDLE, `hready_in && htrans[1]` at a rising edge.
  - On accept, latch haddr and hwrite.
  - Decode `idx = (haddr - BASE_ADDR) >> SLV_SHIFT`. The address is valid iff `haddr >= BASE_ADDR` and `idx < NSLV`.
  - htrans IDLE or BUSY, or hready_in=0, is ignored and the block stays in IDLE.
- hsize and hburst are not inputs. Every transfer is 32-bit single; SEQ is handled exactly like NONSEQ.
- State machine:
  - IDLE: hreadyout=1.
    - Valid accept -> LATCH.
    - Invalid-address accept -> ERR1.
  - LATCH: hreadyout=0.
    - Drive paddr = latched address, pwrite = latched hwrite.
    - For a write, register pwdata <= hwdata at the edge leaving LATCH.
    - -> SETUP.
  - SETUP: psel[idx]=1, penable=0, hreadyout=0. -> ACCESS.
  - ACCESS: psel[idx]=1, penable=1, hreadyout=0. At the edge where pready=1:
    - Read: hrdata <= prdata.
    - psel and penable go to 0.
    - Go to IDLE with hreadyout=1 and hresp=0.
  - ERR1: hreadyout=0, hresp=1. -> ERR2.
  - ERR2: hreadyout=1, hresp=1. -> IDLE; hresp returns to 0.
- Latency, zero-wait APB: accept at edge E0; LATCH, SETUP and ACCESS occupy cycles 1-3; hreadyout=1 with data in cycle 4. Each pready=0 cycle adds one cycle.
- Timeout:
  - The counter increments each ACCESS cycle with pready=0 and clears on leaving ACCESS.
  - When TIMEOUT != 0 and the count reaches TIMEOUT, drop psel/penable and go to ERR1. hrdata is unchanged.
- Back-to-back: a new accept is allowed in the IDLE cycle in which the previous completion is signalled (hreadyout=1). There is no address pipelining while busy.
- paddr, pwrite and pwdata hold their last values in IDLE.
- hrdata holds its value until the next read completes.

Optional Feature:
- Macro: PSLVERR_EN.
- Defined:
  - When pready=1 and pslverr=1 in ACCESS, go to ERR1 instead of IDLE, giving a two-cycle AHB ERROR.
  - For a read with pslverr=1, hrdata is not updated.
- Undefined: the pslverr input is ignored, and every pready completion returns OKAY.

Test Plan:
- Single write: htrans=2, hwrite=1, haddr=32'h8000_0000, hwdata=32'h24, pready=1.
  - Required: psel=4'b0001 in cycle 2, penable=1 in cycle 3, pwdata=32'h24, pwrite=1, paddr=32'h8000_0000.
  - Required: hreadyout low for cycles 1-3, then 1 with hresp=0.
- Single read: haddr=32'h8000_2004, prdata=32'hCAFE_F00D, pready low for 2 ACCESS cycles.
  - Required: psel=4'b0100, and hreadyout low for 5 cycles.
  - Required: hrdata=32'hCAFE_F00D with hreadyout=1.
- Out-of-window: haddr=32'h8000_4000 (idx=4) and haddr=32'h7FFF_FFFC.
  - Required: no psel activity.
  - Required: hreadyout 0 then 1 with hresp=1 for 2 cycles, then OKAY.
- Timeout: TIMEOUT=16, pready held 0.
  - Required: penable high for exactly 16 cycles, then psel=0 and an ERROR response.
  - Required: the next transfer with pready=1 completes OKAY.
- Reset and idle filtering:
  - Assert hresetn=0 during ACCESS. Required: psel/penable 0 immediately, hreadyout=1.
  - htrans=0 or 1, or hready_in=0. Required: no transfer is started.
- PSLVERR_EN: read with pready=1 and pslverr=1.
  - With the macro defined: ERROR response, hrdata unchanged.
  - Without the macro: OKAY response, hrdata=prdata.
